csr_row_sequencer: RTL and testbench
====================================

# csr_row_sequencer

Control block that walks a CSR sparse matrix row by row and sequences the CSR row fetcher and the per-row add/accumulate datapath behind it. It reads the row-pointer table through a one-cycle synchronous read port and splits each row's nonzeros into chunks of at most FETCH_SIZE. It issues one fetch descriptor per chunk (row, base address, count, first/last flags) over a valid/ready handshake. Empty rows still get one zero-count descriptor, so every output row receives a bias-only result.

## Interface
Parameters:
- N_ROWS, 5: number of matrix rows; the row-pointer table has N_ROWS+1 entries.
- FETCH_SIZE, 2: maximum nonzeros per descriptor; matches the fetcher width.
- ADDR_WIDTH, 16: width of row-pointer values, row index and nonzero addresses.
- CNT_WIDTH, $clog2(FETCH_SIZE+1): width of the count field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  pulse to begin a pass; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last descriptor of row N_ROWS-1 is accepted.
- rowptr_rd  out  1  row-pointer read strobe.
- rowptr_addr  out  ADDR_WIDTH  row-pointer table index.
- rowptr_data  in  ADDR_WIDTH  read data, valid exactly 1 cycle after rowptr_rd.
- fetch_valid  out  1  descriptor valid.
- fetch_ready  in  1  downstream accepts the descriptor.
- fetch_row  out  ADDR_WIDTH  row index of the descriptor.
- fetch_base  out  ADDR_WIDTH  address of the first nonzero in the chunk.
- fetch_count  out  CNT_WIDTH  nonzeros in the chunk, 0..FETCH_SIZE.
- fetch_first  out  1  first chunk of the row; the accumulator clears and loads bias.
- fetch_last  out  1  last chunk of the row; the accumulator commits its result.
- error  out  1  sticky; only present as a live signal under CSR_SEQ_ERR_CHECK_EN.

## Operation
- Registers:
  - row: current row index.
  - cur: next nonzero address to issue.
  - end_ptr: end address of the current row.
  - first_pend: the next descriptor is the row's first chunk.
- States and transitions:
  - IDLE: on start, go to REQ0 and set busy.
  - REQ0: rowptr_rd=1, rowptr_addr=0; go to WAIT0.
  - WAIT0: cur<=rowptr_data, row<=0; go to REQ.
  - REQ: rowptr_rd=1, rowptr_addr=row+1; go to WAIT.
  - WAIT: end_ptr<=rowptr_data, first_pend<=1; go to ISSUE (or to ERR, see Configuration).
  - ISSUE: fetch_valid=1.
    - fetch_count = min(end_ptr-cur, FETCH_SIZE); fetch_base=cur; fetch_row=row; fetch_first=first_pend.
    - fetch_last = (end_ptr-cur <= FETCH_SIZE), which includes the zero-count case.
    - On handshake (fetch_valid & fetch_ready): cur<=cur+fetch_count, first_pend<=0.
    - If fetch_last and row==N_ROWS-1: go to DONE.
    - If fetch_last otherwise: row<=row+1 and go to REQ.
    - Otherwise stay in ISSUE.
  - DONE: done=1 for one cycle, busy<=0; go to IDLE.
- Descriptor fields are held stable while fetch_valid=1 and fetch_ready=0.
- fetch_valid never drops without a handshake, except on reset.
- The difference end_ptr-cur is computed at ADDR_WIDTH+1 bits; the count is saturated at FETCH_SIZE.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, rowptr_rd=0, rowptr_addr=0, fetch_valid=0, fetch_row=0, fetch_base=0, fetch_count=0, fetch_first=0, fetch_last=0, error=0.
  - Registers and state are cleared; state goes to IDLE.
- Start latency: start sampled at edge 0, then REQ0 in cycle 1, WAIT0 in cycle 2, REQ in cycle 3, WAIT in cycle 4. The first fetch_valid is high in cycle 5.
- Row switch: after the last-chunk handshake at edge k, REQ is in cycle k+1, WAIT in k+2, and the next row's fetch_valid is high in cycle k+3.
- Back-to-back chunks within a row: one per cycle while fetch_ready=1.
- done is asserted in the cycle after the final handshake. busy falls in the same cycle done pulses. A start in the DONE cycle is ignored.
- Reset mid-pass: all outputs return to their reset values immediately (asynchronously), including fetch_valid. No done pulse is produced.

## Configuration
- CSR_SEQ_ERR_CHECK_EN defined:
  - In WAIT, a row-pointer value less than cur sends the FSM to ERR.
  - ERR sets error=1 (sticky until reset), drops busy, pulses done, and returns to IDLE.
  - Further start pulses are ignored until reset.
- CSR_SEQ_ERR_CHECK_EN undefined:
  - error is tied to 0 and there is no ERR state.
  - A decreasing row pointer produces an unspecified descriptor stream, but the FSM still terminates.

## Test plan
- Nominal pass. Setup: N_ROWS=5, FETCH_SIZE=2, rowptr=[0,2,2,5,6,10], fetch_ready=1. Required: exactly 7 descriptors (row,base,count,first,last) = (0,0,2,1,1), (1,2,0,1,1), (2,2,2,1,0), (2,4,1,0,1), (3,5,1,1,1), (4,6,2,1,0), (4,8,2,0,1). done pulses once; first fetch_valid is 5 cycles after start.
- Backpressure. Same table, fetch_ready toggling 0/1 every cycle. Required: identical descriptor sequence; fields stable while stalled; no dropped or duplicated chunk.
- All-empty matrix. rowptr=[3,3,3,3,3,3]. Required: 5 descriptors, each count=0, base=3, first=1, last=1.
- Reset mid-row. Assert rst_n=0 while stalled on row 2 chunk 1. Required: fetch_valid, busy and done are 0 in the same cycle. After release, start replays from row 0.
- Start while busy. Pulse start during row 1. Required: no restart; the sequence is unchanged; exactly one done.
- Error check (CSR_SEQ_ERR_CHECK_EN defined). rowptr=[0,4,2,...]. Required: row 0 issues (0,0,2,1,0) and (0,2,2,0,1), then error=1 with a done pulse and no row-1 descriptor.

Source files
------------

// File: rtl/csr_row_sequencer.sv
// csr_row_sequencer: walks a CSR row-pointer table row by row and issues one
// fetch descriptor per chunk of at most FETCH_SIZE nonzeros. Empty rows still
// produce a single zero-count descriptor so every row gets a bias-only result.
// Optional feature: define CSR_SEQ_ERR_CHECK_EN to trap decreasing row pointers
// into a sticky error state; otherwise error is tied low.
module csr_row_sequencer #(
    parameter int N_ROWS     = 5,
    parameter int FETCH_SIZE = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(FETCH_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rowptr_rd,
    output logic [ADDR_WIDTH-1:0] rowptr_addr,
    input  logic [ADDR_WIDTH-1:0] rowptr_data,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] fetch_row,
    output logic [ADDR_WIDTH-1:0] fetch_base,
    output logic [CNT_WIDTH-1:0]  fetch_count,
    output logic                  fetch_first,
    output logic                  fetch_last,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ,
        WAIT,
        ISSUE,
        DONE
`ifdef CSR_SEQ_ERR_CHECK_EN
        , ERR
`endif
    } state_t;

    localparam logic [ADDR_WIDTH:0]   FETCH_SIZE_EXT = (ADDR_WIDTH + 1)'(FETCH_SIZE);
    localparam logic [CNT_WIDTH-1:0]  FETCH_SIZE_CNT = CNT_WIDTH'(FETCH_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW       = ADDR_WIDTH'(N_ROWS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] end_ptr;
    logic                  first_pend;

    logic [ADDR_WIDTH-1:0] desc_end;
    logic [ADDR_WIDTH-1:0] desc_cur;
    logic [ADDR_WIDTH:0]   diff;
    logic                  next_last;
    logic [CNT_WIDTH-1:0]  next_count;
    logic                  handshake;

    // Row, base and first flag come straight from the walk registers, which
    // only move on a handshake, so they stay stable while stalled.
    assign fetch_row   = row;
    assign fetch_base  = cur;
    assign fetch_first = first_pend;
    assign handshake   = fetch_valid & fetch_ready;

`ifdef CSR_SEQ_ERR_CHECK_EN
    logic error_r;
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    // Next chunk's count/last: in WAIT the row end arrives on rowptr_data, in
    // ISSUE the next chunk starts where the current one ends; the difference
    // is one bit wider so a decreasing pointer saturates instead of wrapping.
    always_comb begin
        desc_end = end_ptr;
        desc_cur = cur;
        if (state == WAIT) begin
            desc_end = rowptr_data;
        end
        if (state == ISSUE) begin
            desc_cur = cur + ADDR_WIDTH'(fetch_count);
        end
        diff       = {1'b0, desc_end} - {1'b0, desc_cur};
        next_last  = (diff <= FETCH_SIZE_EXT);
        next_count = next_last ? diff[CNT_WIDTH-1:0] : FETCH_SIZE_CNT;
    end

    // Sequencer FSM with all control outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            cur         <= '0;
            end_ptr     <= '0;
            first_pend  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rowptr_rd   <= 1'b0;
            rowptr_addr <= '0;
            fetch_valid <= 1'b0;
            fetch_count <= '0;
            fetch_last  <= 1'b0;
`ifdef CSR_SEQ_ERR_CHECK_EN
            error_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef CSR_SEQ_ERR_CHECK_EN
                    if (start && !error_r) begin
`else
                    if (start) begin
`endif
                        state       <= REQ0;
                        busy        <= 1'b1;
                        rowptr_rd   <= 1'b1;
                        rowptr_addr <= '0;
                    end
                end
                REQ0: begin
                    rowptr_rd <= 1'b0;
                    state     <= WAIT0;
                end
                WAIT0: begin
                    cur         <= rowptr_data;
                    row         <= '0;
                    rowptr_rd   <= 1'b1;
                    rowptr_addr <= ADDR_WIDTH'(1);
                    state       <= REQ;
                end
                REQ: begin
                    rowptr_rd <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    end_ptr <= rowptr_data;
`ifdef CSR_SEQ_ERR_CHECK_EN
                    if (rowptr_data < cur) begin
                        error_r <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ERR;
                    end else begin
                        first_pend  <= 1'b1;
                        fetch_valid <= 1'b1;
                        fetch_count <= next_count;
                        fetch_last  <= next_last;
                        state       <= ISSUE;
                    end
`else
                    first_pend  <= 1'b1;
                    fetch_valid <= 1'b1;
                    fetch_count <= next_count;
                    fetch_last  <= next_last;
                    state       <= ISSUE;
`endif
                end
                ISSUE: begin
                    if (handshake) begin
                        cur        <= cur + ADDR_WIDTH'(fetch_count);
                        first_pend <= 1'b0;
                        if (fetch_last) begin
                            fetch_valid <= 1'b0;
                            if (row == LAST_ROW) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                row         <= row + ADDR_WIDTH'(1);
                                rowptr_rd   <= 1'b1;
                                rowptr_addr <= row + ADDR_WIDTH'(2);
                                state       <= REQ;
                            end
                        end else begin
                            fetch_count <= next_count;
                            fetch_last  <= next_last;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
`ifdef CSR_SEQ_ERR_CHECK_EN
                ERR: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_row_sequencer.sv
// tb_csr_row_sequencer: scoreboard bench for csr_row_sequencer. Expected
// descriptors come from a chunking model of the row-pointer table; a monitor
// pops and compares on every accepted descriptor.
module tb_csr_row_sequencer;

    localparam int N_ROWS     = 5;
    localparam int FETCH_SIZE = 2;
    localparam int ADDR_WIDTH = 16;
    localparam int CNT_WIDTH  = $clog2(FETCH_SIZE + 1);

    typedef struct {
        int row;
        int base;
        int count;
        bit first;
        bit last;
    } desc_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  rowptr_rd;
    logic [ADDR_WIDTH-1:0] rowptr_addr;
    logic [ADDR_WIDTH-1:0] rowptr_data = '0;
    logic                  fetch_valid;
    logic                  fetch_ready = 1'b0;
    logic [ADDR_WIDTH-1:0] fetch_row;
    logic [ADDR_WIDTH-1:0] fetch_base;
    logic [CNT_WIDTH-1:0]  fetch_count;
    logic                  fetch_first;
    logic                  fetch_last;
    logic                  error;

    logic [ADDR_WIDTH-1:0] rp_table [0:N_ROWS];
    desc_t                 exp_q [$];

    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int n_done = 0;
    int n_desc = 0;

    bit                    prev_stall = 1'b0;
    logic [ADDR_WIDTH-1:0] snap_row;
    logic [ADDR_WIDTH-1:0] snap_base;
    logic [CNT_WIDTH-1:0]  snap_count;
    logic                  snap_first;
    logic                  snap_last;

    csr_row_sequencer #(
        .N_ROWS(N_ROWS),
        .FETCH_SIZE(FETCH_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rowptr_rd(rowptr_rd),
        .rowptr_addr(rowptr_addr),
        .rowptr_data(rowptr_data),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_row(fetch_row),
        .fetch_base(fetch_base),
        .fetch_count(fetch_count),
        .fetch_first(fetch_first),
        .fetch_last(fetch_last),
        .error(error)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Row-pointer table with a one-cycle synchronous read.
    always @(posedge clk) begin
        if (rowptr_rd && rowptr_addr <= ADDR_WIDTH'(N_ROWS)) begin
            rowptr_data <= rp_table[rowptr_addr[2:0]];
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Chunk every row into pieces of at most FETCH_SIZE; empty rows yield one zero-count piece.
    function automatic void buildExpected();
        exp_q.delete();
        for (int r = 0; r < N_ROWS; r++) begin
            int c;
            int e;
            bit first;
            bit last;
            c = int'(rp_table[r]);
            e = int'(rp_table[r + 1]);
            first = 1'b1;
            do begin
                desc_t d;
                int rem;
                rem = e - c;
                last = (rem <= FETCH_SIZE);
                d.row = r;
                d.base = c;
                d.count = last ? rem : FETCH_SIZE;
                d.first = first;
                d.last = last;
                exp_q.push_back(d);
                c = c + d.count;
                first = 1'b0;
            end while (!last);
        end
    endfunction

    task automatic setTable(input int v [0:N_ROWS]);
        for (int i = 0; i <= N_ROWS; i++) rp_table[i] = ADDR_WIDTH'(v[i]);
    endtask

    // Monitor: compare accepted descriptors, hold stability while stalled, done/busy relation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                checkOutput("busy_at_done", busy, 0);
            end
            if (prev_stall) begin
                checkOutput("hold_valid", fetch_valid, 1);
                checkOutput("hold_row", fetch_row, snap_row);
                checkOutput("hold_base", fetch_base, snap_base);
                checkOutput("hold_count", fetch_count, snap_count);
                checkOutput("hold_first", fetch_first, snap_first);
                checkOutput("hold_last", fetch_last, snap_last);
            end
            if (fetch_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (fetch_valid && fetch_ready) begin
                n_desc++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_desc_row", fetch_row, -1);
                end else begin
                    desc_t d;
                    d = exp_q.pop_front();
                    checkOutput("desc_row", fetch_row, d.row);
                    checkOutput("desc_base", fetch_base, d.base);
                    checkOutput("desc_count", fetch_count, d.count);
                    checkOutput("desc_first", fetch_first, d.first);
                    checkOutput("desc_last", fetch_last, d.last);
                end
            end
            prev_stall = fetch_valid && !fetch_ready;
            snap_row   = fetch_row;
            snap_base  = fetch_base;
            snap_count = fetch_count;
            snap_first = fetch_first;
            snap_last  = fetch_last;
        end
    end

    task automatic pulseStart();
        n_done = 0;
        n_desc = 0;
        first_valid_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // ready_mode: 0 = always ready, 1 = toggle each cycle, 2 = random.
    task automatic applyStimulus(input int ready_mode, input bit extra_start);
        bit sent;
        int budget;
        sent = 1'b0;
        budget = 0;
        fetch_ready = (ready_mode == 0);
        pulseStart();
        while (n_done == 0 && budget < 3000) begin
            case (ready_mode)
                0:       fetch_ready = 1'b1;
                1:       fetch_ready = ~fetch_ready;
                default: fetch_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = 1'b0;
            if (extra_start && !sent && n_desc == 1) begin
                start = 1'b1;
                sent = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        checkOutput("done_timeout", (n_done == 0), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_pulses", n_done, 1);
        checkOutput("leftover_desc", exp_q.size(), 0);
        checkOutput("busy_after", busy, 0);
`ifndef CSR_SEQ_ERR_CHECK_EN
        checkOutput("error_low", error, 0);
`endif
    endtask

    initial begin
        int nominal [0:N_ROWS];
        int empty [0:N_ROWS];
        int rnd [0:N_ROWS];
        int b;
        nominal = '{0, 2, 2, 5, 6, 10};
        empty   = '{3, 3, 3, 3, 3, 3};

        // Reset state
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rowptr_rd", rowptr_rd, 0);
        checkOutput("rst_rowptr_addr", rowptr_addr, 0);
        checkOutput("rst_fetch_valid", fetch_valid, 0);
        checkOutput("rst_fetch_row", fetch_row, 0);
        checkOutput("rst_fetch_base", fetch_base, 0);
        checkOutput("rst_fetch_count", fetch_count, 0);
        checkOutput("rst_fetch_first", fetch_first, 0);
        checkOutput("rst_fetch_last", fetch_last, 0);
        checkOutput("rst_error", error, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nominal pass with latency and descriptor count
        setTable(nominal);
        buildExpected();
        applyStimulus(0, 1'b0);
        checkOutput("nominal_desc_total", n_desc, 7);
        checkOutput("start_latency", first_valid_cyc - start_cyc, 5);

        // Backpressure with toggling ready
        buildExpected();
        applyStimulus(1, 1'b0);
        checkOutput("bp_desc_total", n_desc, 7);

        // All-empty matrix
        setTable(empty);
        buildExpected();
        applyStimulus(0, 1'b0);
        checkOutput("empty_desc_total", n_desc, 5);

        // Start while busy must be ignored
        setTable(nominal);
        buildExpected();
        applyStimulus(0, 1'b1);
        checkOutput("restart_desc_total", n_desc, 7);

        // Reset while stalled on row 2 chunk 1
        buildExpected();
        fetch_ready = 1'b1;
        pulseStart();
        b = 0;
        while (n_desc < 3 && b < 200) begin
            fetch_ready = 1'b1;
            @(posedge clk); #1;
            b++;
        end
        fetch_ready = 1'b0;
        b = 0;
        while (!fetch_valid && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        checkOutput("stall_valid", fetch_valid, 1);
        checkOutput("stall_row", fetch_row, 2);
        checkOutput("stall_base", fetch_base, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", fetch_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_row", fetch_row, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_no_done", n_done, 0);
        buildExpected();
        applyStimulus(0, 1'b0);
        checkOutput("replay_desc_total", n_desc, 7);

        // Randomized tables with random backpressure
        for (int p = 0; p < 8; p++) begin
            rnd[0] = $urandom_range(0, 20);
            for (int i = 1; i <= N_ROWS; i++) rnd[i] = rnd[i - 1] + $urandom_range(0, 5);
            setTable(rnd);
            buildExpected();
            applyStimulus(2, ($urandom_range(0, 1) == 1));
        end

`ifdef CSR_SEQ_ERR_CHECK_EN
        // Decreasing row pointer traps into the sticky error
        begin
            int bad [0:N_ROWS];
            desc_t d;
            bad = '{0, 4, 2, 6, 6, 6};
            setTable(bad);
            exp_q.delete();
            d.row = 0; d.base = 0; d.count = 2; d.first = 1'b1; d.last = 1'b0;
            exp_q.push_back(d);
            d.row = 0; d.base = 2; d.count = 2; d.first = 1'b0; d.last = 1'b1;
            exp_q.push_back(d);
            applyStimulus(0, 1'b0);
            checkOutput("err_desc_total", n_desc, 2);
            checkOutput("err_flag", error, 1);
            pulseStart();
            repeat (3) @(posedge clk);
            #1;
            checkOutput("err_start_ignored", busy, 0);
            checkOutput("err_sticky", error, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
